frontend_cmd_queue: RTL and testbench

- Upstream stage of the command scheduler. Buffers frontend commands, with their write data, from the host/accelerator side.
- Issues queued commands to the scheduler one per cycle while the scheduler's `ba_cmd_pm` is high.
- Tracks outstanding reads in issue order and returns scheduler read data to the host, tagged with row/col.
- Provides a flush sequence for phase boundaries (e.g. weight load to compute).

---
 rtl/frontend_cmd_queue.sv | 270 +++++++++++++++++++++++++++
 tb/tb_frontend_cmd_queue.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_cmd_queue.sv
// Frontend command queue: buffers host commands with write data, issues them to the scheduler,
// tracks outstanding read tags and runs the flush handshake. Optional macro: CMDQ_STATS_EN.
module frontend_cmd_queue #(
  parameter int OP_BITS    = 2,
  parameter int DTYPE_BITS = 2,
  parameter int ROW_BITS   = 14,
  parameter int COL_BITS   = 10,
  parameter int CMD_W      = OP_BITS + DTYPE_BITS + ROW_BITS + COL_BITS,
  parameter int DATA_W     = 1024,
  parameter int CMD_DEPTH  = 8,
  parameter int RD_DEPTH   = 16,
  parameter logic [OP_BITS-1:0] OP_READ  = 2'd1,
  parameter logic [OP_BITS-1:0] OP_WRITE = 2'd2
) (
  input  logic                         clk,
  input  logic                         power_on_rst_n,
  input  logic                         host_cmd_valid,
  output logic                         host_cmd_ready,
  input  logic [CMD_W-1:0]             host_cmd,
  input  logic [DATA_W-1:0]            host_wdata,
  output logic [CMD_W-1:0]             command,
  output logic [DATA_W-1:0]            write_data,
  output logic                         valid,
  input  logic                         ba_cmd_pm,
  input  logic [DATA_W-1:0]            read_data,
  input  logic                         read_data_valid,
  output logic [DATA_W-1:0]            host_rdata,
  output logic                         host_rdata_valid,
  output logic [ROW_BITS+COL_BITS-1:0] host_rtag,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic [$clog2(RD_DEPTH):0]    rd_outstanding,
`ifdef CMDQ_STATS_EN
  output logic [31:0]                  stat_wr_issued,
  output logic [31:0]                  stat_rd_issued,
  output logic [31:0]                  stat_pm_stall_cycles,
`endif
  output logic                         err_underflow
);

  localparam int CPW   = $clog2(CMD_DEPTH);
  localparam int RPW   = $clog2(RD_DEPTH);
  localparam int TAG_W = ROW_BITS + COL_BITS;
  localparam logic [CPW:0] CMD_FULL_CNT = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW:0] RD_FULL_CNT  = (RPW+1)'(RD_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             r_state;
  logic [CMD_W-1:0]   r_cmd_mem   [CMD_DEPTH];
  logic [DATA_W-1:0]  r_wdata_mem [CMD_DEPTH];
  logic [CPW-1:0]     r_cmd_wptr;
  logic [CPW-1:0]     r_cmd_rptr;
  logic [CPW:0]       r_cmd_count;
  logic [TAG_W-1:0]   r_tag_mem   [RD_DEPTH];
  logic [RPW-1:0]     r_tag_wptr;
  logic [RPW-1:0]     r_tag_rptr;
  logic [RPW:0]       r_rd_cnt;
  logic [CMD_W-1:0]   r_command;
  logic [DATA_W-1:0]  r_write_data;
  logic               r_valid;
  logic [DATA_W-1:0]  r_host_rdata;
  logic               r_host_rdata_valid;
  logic [TAG_W-1:0]   r_host_rtag;
  logic               r_flush_done;
  logic               r_err_underflow;

  logic [CMD_W-1:0]   w_head_cmd;
  logic [OP_BITS-1:0] w_head_op;
  logic [OP_BITS-1:0] w_in_op;
  logic               w_push;
  logic               w_launch;
  logic               w_launch_rd;
  logic               w_ret_ok;

  assign w_head_cmd  = r_cmd_mem[r_cmd_rptr];
  assign w_head_op   = w_head_cmd[CMD_W-1 -: OP_BITS];
  assign w_in_op     = host_cmd[CMD_W-1 -: OP_BITS];
  assign host_cmd_ready = (r_cmd_count != CMD_FULL_CNT) && (r_state != ST_FLUSH);
  assign w_push      = host_cmd_valid && host_cmd_ready;
  // A read at the head waits while every tag slot is in use; it blocks the whole queue.
  assign w_launch    = ba_cmd_pm && (r_cmd_count != '0) &&
                       !((w_head_op == OP_READ) && (r_rd_cnt == RD_FULL_CNT));
  assign w_launch_rd = w_launch && (w_head_op == OP_READ);
  assign w_ret_ok    = read_data_valid && (r_rd_cnt != '0);

  // Command and write-data storage; payload needs no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_cmd_wptr]   <= host_cmd;
      r_wdata_mem[r_cmd_wptr] <= (w_in_op == OP_WRITE) ? host_wdata : '0;
    end
  end

  // Tag storage for reads in flight.
  always_ff @(posedge clk) begin
    if (w_launch_rd) begin
      r_tag_mem[r_tag_wptr] <= w_head_cmd[TAG_W-1:0];
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_push) begin
        r_cmd_wptr <= r_cmd_wptr + CPW'(1);
      end
      if (w_launch) begin
        r_cmd_rptr <= r_cmd_rptr + CPW'(1);
      end
      case ({w_push, w_launch})
        2'b10:   r_cmd_count <= r_cmd_count + (CPW+1)'(1);
        2'b01:   r_cmd_count <= r_cmd_count - (CPW+1)'(1);
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // Tag FIFO pointers and outstanding-read count; a return with nothing outstanding never decrements.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_tag_wptr <= '0;
      r_tag_rptr <= '0;
      r_rd_cnt   <= '0;
    end else begin
      if (w_launch_rd) begin
        r_tag_wptr <= r_tag_wptr + RPW'(1);
      end
      if (w_ret_ok) begin
        r_tag_rptr <= r_tag_rptr + RPW'(1);
      end
      case ({w_launch_rd, w_ret_ok})
        2'b10:   r_rd_cnt <= r_rd_cnt + (RPW+1)'(1);
        2'b01:   r_rd_cnt <= r_rd_cnt - (RPW+1)'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  // Issue register toward the scheduler; zeroed on cycles without a launch.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_command    <= '0;
      r_write_data <= '0;
      r_valid      <= 1'b0;
    end else if (w_launch) begin
      r_command    <= w_head_cmd;
      r_write_data <= r_wdata_mem[r_cmd_rptr];
      r_valid      <= 1'b1;
    end else begin
      r_command    <= '0;
      r_write_data <= '0;
      r_valid      <= 1'b0;
    end
  end

  // Read return path; an unmatched beat is still forwarded with a zero tag.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_host_rdata       <= '0;
      r_host_rdata_valid <= 1'b0;
      r_host_rtag        <= '0;
      r_err_underflow    <= 1'b0;
    end else begin
      r_host_rdata_valid <= read_data_valid;
      if (read_data_valid) begin
        r_host_rdata <= read_data;
        r_host_rtag  <= w_ret_ok ? r_tag_mem[r_tag_rptr] : '0;
      end else begin
        r_host_rdata <= '0;
        r_host_rtag  <= '0;
      end
      if (read_data_valid && !w_ret_ok) begin
        r_err_underflow <= 1'b1;
      end else begin
        r_err_underflow <= r_err_underflow;
      end
    end
  end

  // Flush sequencing with a registered one-cycle done pulse on entry to DONE.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_flush_done <= 1'b0;
          r_state      <= flush_req ? ST_FLUSH : ST_RUN;
        end
        ST_FLUSH: begin
          if ((r_cmd_count == '0) && (r_rd_cnt == '0) && !r_valid) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end else begin
            r_state      <= ST_FLUSH;
            r_flush_done <= 1'b0;
          end
        end
        ST_DONE: begin
          r_flush_done <= 1'b0;
          r_state      <= flush_req ? ST_DONE : ST_RUN;
        end
        default: begin
          r_flush_done <= 1'b0;
          r_state      <= ST_RUN;
        end
      endcase
    end
  end

`ifdef CMDQ_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_stall;

  // Saturating issue and back-pressure statistics.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      r_stat_wr    <= 32'd0;
      r_stat_rd    <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if (w_launch && (w_head_op == OP_WRITE)) begin
        r_stat_wr <= sat_inc(r_stat_wr);
      end
      if (w_launch_rd) begin
        r_stat_rd <= sat_inc(r_stat_rd);
      end
      if ((r_cmd_count != '0) && !ba_cmd_pm) begin
        r_stat_stall <= sat_inc(r_stat_stall);
      end
    end
  end

  assign stat_wr_issued       = r_stat_wr;
  assign stat_rd_issued       = r_stat_rd;
  assign stat_pm_stall_cycles = r_stat_stall;
`endif

  assign command          = r_command;
  assign write_data       = r_write_data;
  assign valid            = r_valid;
  assign host_rdata       = r_host_rdata;
  assign host_rdata_valid = r_host_rdata_valid;
  assign host_rtag        = r_host_rtag;
  assign flush_done       = r_flush_done;
  assign cmd_count        = r_cmd_count;
  assign rd_outstanding   = r_rd_cnt;
  assign err_underflow    = r_err_underflow;

endmodule

// File: tb/tb_frontend_cmd_queue.sv
// Bench for frontend_cmd_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_frontend_cmd_queue;
  localparam int CW = 28;
  localparam int DW = 1024;
  localparam int TW = 24;
  localparam int CD = 8;
  localparam int RD = 16;
  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_cmd_valid = 1'b0;
  logic host_cmd_ready;
  logic [CW-1:0] host_cmd = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [CW-1:0] command;
  logic [DW-1:0] write_data;
  logic valid;
  logic ba_cmd_pm = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic read_data_valid = 1'b0;
  logic [DW-1:0] host_rdata;
  logic host_rdata_valid;
  logic [TW-1:0] host_rtag;
  logic flush_req = 1'b0;
  logic flush_done;
  logic [3:0] cmd_count;
  logic [4:0] rd_outstanding;
  logic err_underflow;
`ifdef CMDQ_STATS_EN
  logic [31:0] stat_wr_issued, stat_rd_issued, stat_pm_stall_cycles;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frontend_cmd_queue dut (
    .clk(clk), .power_on_rst_n(rst_n),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd(host_cmd), .host_wdata(host_wdata),
    .command(command), .write_data(write_data), .valid(valid),
    .ba_cmd_pm(ba_cmd_pm), .read_data(read_data), .read_data_valid(read_data_valid),
    .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid), .host_rtag(host_rtag),
    .flush_req(flush_req), .flush_done(flush_done),
    .cmd_count(cmd_count), .rd_outstanding(rd_outstanding),
`ifdef CMDQ_STATS_EN
    .stat_wr_issued(stat_wr_issued), .stat_rd_issued(stat_rd_issued),
    .stat_pm_stall_cycles(stat_pm_stall_cycles),
`endif
    .err_underflow(err_underflow)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [1:0] op, input int row, input int col);
    mk = {op, 2'b00, 14'(row), 10'(col)};
  endfunction

  function automatic logic [TW-1:0] tg(input int row, input int col);
    tg = {14'(row), 10'(col)};
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom();
    rnd = r;
  endfunction

  // Reference model: the queue holds accepted commands, tq holds tags of reads in flight.
  typedef struct { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];
  logic [TW-1:0] tq[$];
  logic exp_valid = 1'b0, exp_rv = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [CW-1:0] exp_cmd = '0;
  logic [DW-1:0] exp_wd = '0, exp_rd = '0;
  logic [TW-1:0] exp_tag = '0;
  int mode = 0;  // 0 run, 1 flushing, 2 drained

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); tq.delete();
      exp_valid = 1'b0; exp_rv = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_cmd = '0; exp_wd = '0; exp_rd = '0; exp_tag = '0; mode = 0;
    end else begin
      int sz, outst;
      logic go, pv;
      ent_t h;
      sz = mq.size(); outst = tq.size(); pv = exp_valid;
      exp_rv = read_data_valid; exp_rd = '0; exp_tag = '0;
      if (read_data_valid) begin
        exp_rd = read_data;
        if (outst > 0) exp_tag = tq.pop_front();
        else exp_err = 1'b1;
      end
      go = 1'b0;
      if (ba_cmd_pm && sz > 0) go = !(mq[0].c[CW-1 -: 2] == OP_RD && outst == RD);
      exp_valid = go; exp_cmd = '0; exp_wd = '0;
      if (go) begin
        h = mq.pop_front();
        exp_cmd = h.c; exp_wd = h.d;
        if (h.c[CW-1 -: 2] == OP_RD) tq.push_back(h.c[TW-1:0]);
      end
      if (host_cmd_valid && sz < CD && mode != 1) begin
        h.c = host_cmd;
        h.d = (host_cmd[CW-1 -: 2] == OP_WR) ? host_wdata : '0;
        mq.push_back(h);
      end
      exp_done = 1'b0;
      if (mode == 0 && flush_req) mode = 1;
      else if (mode == 1 && sz == 0 && outst == 0 && !pv) begin mode = 2; exp_done = 1'b1; end
      else if (mode == 2 && !flush_req) mode = 0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid", DW'(valid), DW'(exp_valid));
    chk("command", DW'(command), DW'(exp_cmd));
    chk("write_data", write_data, exp_wd);
    chk("rdata_valid", DW'(host_rdata_valid), DW'(exp_rv));
    if (exp_rv) begin
      chk("rdata", host_rdata, exp_rd);
      chk("rtag", DW'(host_rtag), DW'(exp_tag));
    end
    chk("flush_done", DW'(flush_done), DW'(exp_done));
    chk("cmd_count", DW'(cmd_count), DW'(mq.size()));
    chk("rd_outstanding", DW'(rd_outstanding), DW'(tq.size()));
    chk("err_underflow", DW'(err_underflow), DW'(exp_err));
    chk("ready", DW'(host_cmd_ready), DW'(mq.size() < CD && mode != 1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    int n = 0;
    while (!host_cmd_ready && n < 200) begin tick(); n++; end
    chk("push_wait_bound", DW'(n < 200), DW'(1'b1));
    host_cmd_valid = 1'b1; host_cmd = c; host_wdata = d;
    tick();
    host_cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] wd [8];
  logic [DW-1:0] rsave;
  int n_iss;

  initial begin
    repeat (3) tick();
    chk("rst_valid", DW'(valid), DW'(0));
    chk("rst_count", DW'(cmd_count), DW'(0));
    chk("rst_rdata", host_rdata, '0);
    rst_n = 1'b1;
    tick();

    // Eight writes back-to-back with the scheduler ready.
    ba_cmd_pm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wd[i] = rnd();
      host_cmd_valid = 1'b1; host_cmd = mk(OP_WR, 0, i); host_wdata = wd[i];
      tick();
      if (i == 0) chk("t1_first_latency", DW'(valid), DW'(0));
      else begin
        chk("t1_valid", DW'(valid), DW'(1));
        chk("t1_cmd", DW'(command), DW'(mk(OP_WR, 0, i-1)));
        chk("t1_wdata", write_data, wd[i-1]);
      end
    end
    host_cmd_valid = 1'b0;
    tick();
    chk("t1_last_cmd", DW'(command), DW'(mk(OP_WR, 0, 7)));
    chk("t1_last_wdata", write_data, wd[7]);
    tick();
    chk("t1_valid_end", DW'(valid), DW'(0));
    chk("t1_count_end", DW'(cmd_count), DW'(0));

    // Fill with the scheduler stalled, then release it for three cycles.
    ba_cmd_pm = 1'b0;
    for (int i = 0; i < 8; i++) push(mk(OP_WR, 1, i), rnd());
    chk("t2_ready_full", DW'(host_cmd_ready), DW'(0));
    chk("t2_count_full", DW'(cmd_count), DW'(8));
    chk("t2_no_issue", DW'(valid), DW'(0));
    ba_cmd_pm = 1'b1;
    n_iss = 0;
    repeat (3) begin tick(); n_iss += int'(valid); end
    ba_cmd_pm = 1'b0;
    chk("t2_issued3", DW'(n_iss), DW'(3));
    chk("t2_count5", DW'(cmd_count), DW'(5));
    tick();
    chk("t2_stalled", DW'(valid), DW'(0));
    ba_cmd_pm = 1'b1;
    repeat (6) tick();
    chk("t2_drained", DW'(cmd_count), DW'(0));

    // Seventeen reads with no returns: the last blocks at the head.
    for (int i = 0; i < 17; i++) push(mk(OP_RD, 5, i), rnd());
    repeat (4) tick();
    chk("t3_outst16", DW'(rd_outstanding), DW'(16));
    chk("t3_blocked", DW'(cmd_count), DW'(1));
    chk("t3_no_issue", DW'(valid), DW'(0));
    rsave = rnd(); read_data = rsave; read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("t3_rv", DW'(host_rdata_valid), DW'(1));
    chk("t3_rtag", DW'(host_rtag), DW'(24'h001400));
    chk("t3_rdata", host_rdata, rsave);
    tick();
    chk("t3_17th_valid", DW'(valid), DW'(1));
    chk("t3_17th_cmd", DW'(command), DW'(mk(OP_RD, 5, 16)));
    chk("t3_outst_back16", DW'(rd_outstanding), DW'(16));

    // Launch and return in the same cycle.
    read_data = rnd(); read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("t4_rtag_5_1", DW'(host_rtag), DW'(tg(5, 1)));
    push(mk(OP_RD, 6, 0), rnd());
    read_data = rnd(); read_data_valid = 1'b1;
    tick();
    chk("t4_same_cycle_outst", DW'(rd_outstanding), DW'(15));
    chk("t4_same_cycle_issue", DW'(valid), DW'(1));
    chk("t4_rtag_5_2", DW'(host_rtag), DW'(tg(5, 2)));
    repeat (15) begin read_data = rnd(); tick(); end
    read_data_valid = 1'b0;
    chk("t4_last_tag", DW'(host_rtag), DW'(24'h001800));
    chk("t4_outst0", DW'(rd_outstanding), DW'(0));

    // Return with nothing outstanding.
    rsave = rnd(); read_data = rsave; read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
    chk("t5_rv", DW'(host_rdata_valid), DW'(1));
    chk("t5_rtag0", DW'(host_rtag), DW'(0));
    chk("t5_rdata", host_rdata, rsave);
    chk("t5_err", DW'(err_underflow), DW'(1));
    chk("t5_outst0", DW'(rd_outstanding), DW'(0));
    repeat (3) tick();
    chk("t5_err_sticky", DW'(err_underflow), DW'(1));

    // Flush with four reads queued.
    ba_cmd_pm = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(OP_RD, 7, i), '0);
    flush_req = 1'b1;
    tick();
    chk("t6_ready_flush", DW'(host_cmd_ready), DW'(0));
    ba_cmd_pm = 1'b1;
    repeat (5) tick();
    chk("t6_outst4", DW'(rd_outstanding), DW'(4));
    chk("t6_not_done", DW'(flush_done), DW'(0));
    read_data_valid = 1'b1;
    repeat (4) begin read_data = rnd(); tick(); end
    read_data_valid = 1'b0;
    chk("t6_done_not_yet", DW'(flush_done), DW'(0));
    chk("t6_rtag_7_3", DW'(host_rtag), DW'(tg(7, 3)));
    tick();
    chk("t6_done_pulse", DW'(flush_done), DW'(1));
    tick();
    chk("t6_done_once", DW'(flush_done), DW'(0));
    flush_req = 1'b0;
    tick();

    // Reset in the middle of a flush.
    ba_cmd_pm = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(OP_WR, 8, i), rnd());
    flush_req = 1'b1;
    tick();
    ba_cmd_pm = 1'b1;
    tick();
    chk("t7_pre_reset_valid", DW'(valid), DW'(1));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", DW'(valid), DW'(0));
    chk("t7_rst_cmd", DW'(command), DW'(0));
    chk("t7_rst_wdata", write_data, '0);
    chk("t7_rst_count", DW'(cmd_count), DW'(0));
    chk("t7_rst_outst", DW'(rd_outstanding), DW'(0));
    chk("t7_rst_err", DW'(err_underflow), DW'(0));
    chk("t7_rst_done", DW'(flush_done), DW'(0));
    chk("t7_rst_rv", DW'(host_rdata_valid), DW'(0));
    chk("t7_rst_rtag", DW'(host_rtag), DW'(0));
    flush_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n_iss = 0;
    repeat (4) begin tick(); n_iss += int'(valid); end
    chk("t7_discarded", DW'(n_iss), DW'(0));
    chk("t7_count_after", DW'(cmd_count), DW'(0));

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
